// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-pass shift controller time-sharing one logical barrel shifter
module shift_sequencer #(
    parameter int N = 32
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic [N-1:0]         Operand,
    input  logic [$clog2(N)-1:0] Shift_Amt,
    input  logic [2:0]           Op,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [N-1:0]         Result,
    output logic                 Illegal_Op
);
    localparam int KW = $clog2(N);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  operand_q;
    logic [KW-1:0] k_q;
    logic [2:0]    op_q;
    logic [N-1:0]  p_q;

    logic          is_illegal;
    logic          two_pass;
    logic [KW-1:0] comp_k;
    logic [N-1:0]  sh_in;
    logic [KW-1:0] sh_amt;
    logic          sh_left;
    logic [N-1:0]  sh_out;
    logic [N-1:0]  pass2_result;

    assign is_illegal = (op_q > OP_ROR);
    assign two_pass   = (k_q != '0) &&
                        (((op_q == OP_SRA) && operand_q[N-1]) ||
                         (op_q == OP_ROL) || (op_q == OP_ROR));
    // N is a power of two, so (N-k) mod N is the KW-bit two's complement of k
    assign comp_k     = -k_q;

    always_comb begin
        sh_in   = operand_q;
        sh_amt  = k_q;
        sh_left = (op_q == OP_SLL) || (op_q == OP_ROL);
        if (state == PASS2) begin
            case (op_q)
                OP_ROL: begin
                    sh_amt  = comp_k;
                    sh_left = 1'b0;
                end
                OP_ROR: begin
                    sh_amt  = comp_k;
                    sh_left = 1'b1;
                end
                OP_SRA: begin
                    sh_in   = '1;
                    sh_left = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign sh_out       = sh_left ? (sh_in << sh_amt) : (sh_in >> sh_amt);
    // SRA second pass builds a mask of the top k bits from a shifted all-ones word
    assign pass2_result = (op_q == OP_SRA) ? (p_q | ~sh_out) : (p_q | sh_out);

    always_comb begin
        state_nxt = state;
        In_Ready  = 1'b0;
        Out_Valid = 1'b0;
        case (state)
            IDLE: begin
                In_Ready = 1'b1;
                if (In_Valid) state_nxt = PASS1;
            end
            PASS1: state_nxt = (!is_illegal && two_pass) ? PASS2 : DONE;
            PASS2: state_nxt = DONE;
            DONE: begin
                Out_Valid = 1'b1;
                if (Out_Ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            operand_q  <= '0;
            k_q        <= '0;
            op_q       <= '0;
            p_q        <= '0;
            Result     <= '0;
            Illegal_Op <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (In_Valid) begin
                        operand_q <= Operand;
                        k_q       <= Shift_Amt;
                        op_q      <= Op;
                    end
                end
                PASS1: begin
                    p_q <= sh_out;
                    if (is_illegal) begin
                        Result     <= '0;
                        Illegal_Op <= 1'b1;
                    end else if (!two_pass) begin
                        Result     <= sh_out;
                        Illegal_Op <= 1'b0;
                    end
                end
                PASS2: begin
                    Result     <= pass2_result;
                    Illegal_Op <= 1'b0;
                end
                DONE: begin
                    if (Out_Ready) Illegal_Op <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
